// File: rtl/console_tx.sv
// Console transmitter: catches core writes to a character register and an
// exit register, queues characters in a small FIFO and serialises them as
// 8N1 UART frames on txd. exit_valid reports program end once the console
// has drained.
//
// Write handshake: a write is taken on a rising edge when dmem_wready (core
// request) and dmem_wvalid (this block accepts) are both high; dmem_wvalid
// only drops for a character write while the FIFO is full.
module console_tx #(
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] PUTC_ADDR  = 32'h8000001c,
    parameter logic [31:0] EXIT_ADDR  = 32'h8000002c
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        dmem_wready,
    output logic        dmem_wvalid,
    input  logic [31:0] dmem_waddr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic        txd,
    output logic        exit_valid,
    output logic [31:0] exit_code,
    output logic        busy
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam int          CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Transmitter state; kept as a named signal so checkers can bind to it.
    state_t        state;
    logic [15:0]   div_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          exit_pending;

    logic is_putc;
    logic is_exit;
    logic full;
    logic empty;
    logic take;
    logic push;
    logic pop;
    logic bit_end;

    assign is_putc     = (dmem_waddr == PUTC_ADDR);
    assign is_exit     = (dmem_waddr == EXIT_ADDR);
    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    // Full stall is based on the registered count only: a pop this cycle
    // does not open a slot for a write in the same cycle.
    assign dmem_wvalid = !(is_putc && full);
    assign take        = dmem_wready && dmem_wvalid;
    assign push        = take && is_putc && dmem_wstrb[0];
    assign bit_end     = (div_cnt == '0);
    // The FSM loads a byte either from IDLE or straight out of STOP so that
    // queued characters go out as contiguous frames.
    assign pop         = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
    assign busy        = !empty || (state != IDLE);

    // Character storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dmem_wdata[7:0];
        end
    end

    // FIFO pointers and occupancy count; pointers wrap on the power-of-two depth.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame FSM; txd is registered from the current state so the line lags
    // the state by one cycle while every bit still lasts CLK_DIV cycles.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            txd     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        div_cnt <= DIV_LAST;
                        state   <= START;
                    end
                end
                START: begin
                    txd <= 1'b0;
                    if (bit_end) begin
                        div_cnt <= DIV_LAST;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                DATA: begin
                    txd <= shift[0];
                    if (bit_end) begin
                        shift   <= shift >> 1;
                        div_cnt <= DIV_LAST;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                STOP: begin
                    txd <= 1'b1;
                    if (bit_end) begin
                        if (pop) begin
                            shift   <= mem[rd_ptr];
                            div_cnt <= DIV_LAST;
                            state   <= START;
                        end else begin
                            state   <= IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Exit handling: the first exit write wins; exit_valid waits for the
    // console to drain and then stays set until reset.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            exit_pending <= 1'b0;
            exit_code    <= '0;
            exit_valid   <= 1'b0;
        end else begin
            if (take && is_exit && (|dmem_wstrb) && !exit_pending) begin
                exit_code    <= dmem_wdata;
                exit_pending <= 1'b1;
            end
            if (exit_pending && empty && (state == IDLE)) begin
                exit_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_console_tx.sv
// Directed bench for console_tx with CLK_DIV=4 and FIFO_DEPTH=4. A txd
// monitor decodes frames and compares them against bytes queued by the
// write driver; the main sequence checks latency, stalls, exit and reset.
module tb_console_tx;

    localparam int          CLK_DIV    = 4;
    localparam int          FIFO_DEPTH = 4;
    localparam int          FRAME      = 10 * CLK_DIV;
    localparam int          PERIOD     = 10;
    localparam logic [31:0] PUTC_ADDR  = 32'h8000001c;
    localparam logic [31:0] EXIT_ADDR  = 32'h8000002c;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        dmem_wready = 1'b0;
    logic        dmem_wvalid;
    logic [31:0] dmem_waddr = '0;
    logic [31:0] dmem_wdata = '0;
    logic [3:0]  dmem_wstrb = '0;
    logic        txd;
    logic        exit_valid;
    logic [31:0] exit_code;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          take_cyc = 0;
    int          stall_cnt = 0;
    int          txd_edges = 0;
    bit          mon_en = 1'b1;
    logic [7:0]  exp_q[$];
    time         start_q[$];

    console_tx #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH),
        .PUTC_ADDR (PUTC_ADDR),
        .EXIT_ADDR (EXIT_ADDR)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .dmem_wready(dmem_wready),
        .dmem_wvalid(dmem_wvalid),
        .dmem_waddr (dmem_waddr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .txd        (txd),
        .exit_valid (exit_valid),
        .exit_code  (exit_code),
        .busy       (busy)
    );

    // Clock and cycle counter
    always #(PERIOD / 2) clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(txd) txd_edges++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait until n rising edges have occurred, then step just past the edge.
    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one write; holds the request until accepted (bounded).
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        @(negedge clk);
        dmem_wready = 1'b1;
        dmem_waddr  = a;
        dmem_wdata  = d;
        dmem_wstrb  = s;
        #1;
        while (!dmem_wvalid && n < 200) begin
            stall_cnt++;
            n++;
            @(negedge clk);
            #1;
        end
        check("write_accepted", {31'd0, dmem_wvalid}, 32'd1);
        if (a == PUTC_ADDR && s[0] && mon_en) exp_q.push_back(d[7:0]);
        @(posedge clk);
        #1;
        take_cyc    = cyc;
        dmem_wready = 1'b0;
    endtask

    // Wait for all expected bytes to be seen and the block to go quiet.
    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 32'd0);
        check("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    // txd monitor: samples each bit mid-way and scores the decoded byte.
    initial begin : monitor
        logic [7:0] b;
        logic       sb;
        logic       pb;
        forever begin
            @(negedge txd);
            if (mon_en && resetb) begin
                start_q.push_back($time);
                repeat (CLK_DIV / 2) @(posedge clk);
                #1 sb = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(posedge clk);
                    #1 b[i] = txd;
                end
                repeat (CLK_DIV) @(posedge clk);
                #1 pb = txd;
                check("start_bit", {31'd0, sb}, 32'd0);
                check("stop_bit", {31'd0, pb}, 32'd1);
                check("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) check("frame_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Watchdog
    initial begin
        #(50000 * PERIOD);
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed sequence
    initial begin
        int t0;
        int edges;

        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", {31'd0, txd}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_exit_valid", {31'd0, exit_valid}, 32'd0);
        check("reset_exit_code", exit_code, 32'd0);
        check("reset_wvalid", {31'd0, dmem_wvalid}, 32'd1);
        @(negedge clk);
        resetb = 1'b1;

        // Single character: latency, frame length, busy
        bus_write(PUTC_ADDR, 32'h41, 4'b0001);
        t0 = take_cyc;
        check("busy_after_push", {31'd0, busy}, 32'd1);
        wait_cyc(t0 + 1);
        check("latency_edge1_txd", {31'd0, txd}, 32'd1);
        wait_cyc(t0 + 2);
        check("latency_edge2_txd", {31'd0, txd}, 32'd0);
        wait_cyc(t0 + FRAME);
        check("busy_in_stop", {31'd0, busy}, 32'd1);
        wait_cyc(t0 + FRAME + 2);
        check("busy_after_frame", {31'd0, busy}, 32'd0);
        check("txd_after_frame", {31'd0, txd}, 32'd1);
        wait_drain();

        // Six back-to-back characters: stall on full, contiguous frames
        start_q.delete();
        stall_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            bus_write(PUTC_ADDR, 32'($urandom_range(0, 255)), 4'b0001);
        end
        check("full_stall_seen", {31'd0, stall_cnt > 0}, 32'd1);
        wait_drain();
        check("frame_count", start_q.size(), 32'd6);
        for (int i = 1; i < 6; i++) begin
            if (i < start_q.size()) check("frame_gap", 32'(start_q[i] - start_q[i-1]), 32'(FRAME * PERIOD));
        end

        // Exit after a character
        bus_write(PUTC_ADDR, 32'h48, 4'b0001);
        t0 = take_cyc;
        bus_write(EXIT_ADDR, 32'h3, 4'b1111);
        wait_cyc(t0 + 20);
        check("exit_valid_mid_frame", {31'd0, exit_valid}, 32'd0);
        wait_cyc(t0 + FRAME + 1);
        check("exit_valid_before_rise", {31'd0, exit_valid}, 32'd0);
        wait_cyc(t0 + FRAME + 2);
        check("exit_valid_rise", {31'd0, exit_valid}, 32'd1);
        check("exit_code_first", exit_code, 32'h3);
        bus_write(EXIT_ADDR, 32'h7, 4'b0001);
        check("exit_code_held", exit_code, 32'h3);
        bus_write(PUTC_ADDR, 32'h5A, 4'b0001);
        wait_drain();
        check("exit_valid_sticky", {31'd0, exit_valid}, 32'd1);

        // Reset mid-frame with two bytes queued
        mon_en = 1'b0;
        bus_write(PUTC_ADDR, 32'hA5, 4'b0001);
        t0 = take_cyc;
        bus_write(PUTC_ADDR, 32'h11, 4'b0001);
        bus_write(PUTC_ADDR, 32'h22, 4'b0001);
        wait_cyc(t0 + 2 + 15);
        resetb = 1'b0;
        #1;
        check("abort_txd", {31'd0, txd}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_exit_valid", {31'd0, exit_valid}, 32'd0);
        check("abort_exit_code", exit_code, 32'd0);
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        edges = txd_edges;
        repeat (100) @(posedge clk);
        #1;
        check("abort_no_edges", txd_edges - edges, 32'd0);
        check("abort_idle_busy", {31'd0, busy}, 32'd0);
        mon_en = 1'b1;

        // Discarded and ignored writes
        stall_cnt = 0;
        edges = txd_edges;
        bus_write(PUTC_ADDR, 32'h77, 4'b0010);
        check("strb_discard_busy", {31'd0, busy}, 32'd0);
        bus_write(32'h00001000, 32'h55, 4'b1111);
        check("other_addr_busy", {31'd0, busy}, 32'd0);
        check("ignored_no_stall", stall_cnt, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("ignored_no_edges", txd_edges - edges, 32'd0);
        check("ignored_txd", {31'd0, txd}, 32'd1);

        // Normal operation after reset
        bus_write(PUTC_ADDR, 32'hC3, 4'b0001);
        wait_drain();
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
